// File: rtl/error_metric_acc.sv
// Streaming error-metric accumulator placed after an approximate adder and its exact reference.
// Three-stage pipeline (difference, |diff| and square, accumulate) with a drain/report handshake.
//
// state   | meaning
// IDLE    | accepting samples; clear and snap are acted on here
// DRAIN   | input stalled until S1-S3 are empty, then snapshot latched
// REPORT  | res_* held with res_valid until res_ready
module error_metric_acc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32,
  parameter int SAE_W = 64,
  parameter int SSE_W = 100
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   appx,
  input  logic [WIDTH-1:0]   accr,
  input  logic               clear,
  input  logic               snap,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W-1:0]   res_count,
  output logic [CNT_W-1:0]   res_err_count,
  output logic [WIDTH-1:0]   res_max_ae,
  output logic [SAE_W-1:0]   res_sae,
  output logic [SSE_W-1:0]   res_sse,
  output logic               res_sat
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_REPORT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0] W_ONE   = WIDTH'(1);

  state_t state, state_nxt;

  logic clear_now, clear_apply, pend_set, snap_load, clr_pend;
  logic accept, pipe_busy, acc_zero;

  logic               s1_v, s2_v, s3_v;
  logic [WIDTH:0]     s1_diff;
  logic [WIDTH-1:0]   s2_ae, s3_ae;
  logic [2*WIDTH-1:0] s2_sq, s3_sq;

  logic [WIDTH:0]     diff_c;
  logic [WIDTH-1:0]   ae_c;
  logic [2*WIDTH-1:0] ae_ext, sq_c;

  logic [CNT_W-1:0]   count_q, err_q;
  logic [WIDTH-1:0]   max_q;
  logic [SAE_W-1:0]   sae_q;
  logic [SSE_W-1:0]   sse_q;
  logic               sat_q;
  logic [SAE_W:0]     sae_sum;
  logic [SSE_W:0]     sse_sum;
  logic               cnt_full, err_full, err_hit, sae_ovf, sse_ovf;

  // Sign-extend both operands so the difference can never overflow.
  assign diff_c = {appx[WIDTH-1], appx} - {accr[WIDTH-1], accr};
  assign ae_c   = s1_diff[WIDTH] ? (~s1_diff[WIDTH-1:0] + W_ONE) : s1_diff[WIDTH-1:0];
  assign ae_ext = {{WIDTH{1'b0}}, ae_c};
  assign sq_c   = ae_ext * ae_ext;

  assign accept    = in_valid && in_ready;
  assign pipe_busy = s1_v || s2_v || s3_v;
  assign acc_zero  = clear_now || clear_apply;

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    res_valid   = 1'b0;
    clear_now   = 1'b0;
    clear_apply = 1'b0;
    pend_set    = 1'b0;
    snap_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !clear;
        if (clear) clear_now = 1'b1;
        else if (snap) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        pend_set = clear;
        if (!pipe_busy) begin
          snap_load = 1'b1;
          state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        res_valid = 1'b1;
        pend_set  = clear;
        if (res_ready) begin
          state_nxt   = ST_IDLE;
          clear_apply = clr_pend || clear;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= ST_IDLE;
      clr_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_REPORT && res_ready) clr_pend <= 1'b0;
      else if (pend_set) clr_pend <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s3_v    <= 1'b0;
      s1_diff <= '0;
      s2_ae   <= '0;
      s2_sq   <= '0;
      s3_ae   <= '0;
      s3_sq   <= '0;
    end else begin
      if (clear_now) begin
        s1_v <= 1'b0;
        s2_v <= 1'b0;
        s3_v <= 1'b0;
      end else begin
        s1_v <= accept;
        s2_v <= s1_v;
        s3_v <= s2_v;
      end
      s1_diff <= diff_c;
      s2_ae   <= ae_c;
      s2_sq   <= sq_c;
      s3_ae   <= s2_ae;
      s3_sq   <= s2_sq;
    end
  end

  assign sae_sum  = {1'b0, sae_q} + {{(SAE_W+1-WIDTH){1'b0}}, s3_ae};
  assign sse_sum  = {1'b0, sse_q} + {{(SSE_W+1-2*WIDTH){1'b0}}, s3_sq};
  assign cnt_full = &count_q;
  assign err_full = &err_q;
  assign err_hit  = |s3_ae;
  assign sae_ovf  = sae_sum[SAE_W];
  assign sse_ovf  = sse_sum[SSE_W];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q <= '0;
      err_q   <= '0;
      max_q   <= '0;
      sae_q   <= '0;
      sse_q   <= '0;
      sat_q   <= 1'b0;
    end else if (acc_zero) begin
      count_q <= '0;
      err_q   <= '0;
      max_q   <= '0;
      sae_q   <= '0;
      sse_q   <= '0;
      sat_q   <= 1'b0;
    end else if (s3_v) begin
      if (!cnt_full) count_q <= count_q + CNT_ONE;
      if (err_hit && !err_full) err_q <= err_q + CNT_ONE;
      if (s3_ae > max_q) max_q <= s3_ae;
      sae_q <= sae_ovf ? '1 : sae_sum[SAE_W-1:0];
      sse_q <= sse_ovf ? '1 : sse_sum[SSE_W-1:0];
      // Counters and accumulators stick at all-ones; the flag remembers it.
      if (cnt_full || (err_hit && err_full) || sae_ovf || sse_ovf) sat_q <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      res_count     <= '0;
      res_err_count <= '0;
      res_max_ae    <= '0;
      res_sae       <= '0;
      res_sse       <= '0;
    end else if (snap_load) begin
      res_count     <= count_q;
      res_err_count <= err_q;
      res_max_ae    <= max_q;
      res_sae       <= sae_q;
      res_sse       <= sse_q;
    end
  end

  assign res_sat = sat_q;

endmodule

// File: tb/tb_error_metric_acc.sv
// Bench for error_metric_acc: directed scenarios plus random traffic against a timestamped
// sample-queue reference; a default instance and a narrow one that saturates easily.
module tb_error_metric_acc;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        in_valid = 1'b0, clear = 1'b0, snap = 1'b0, res_ready = 1'b0;
  logic [31:0] appx = '0, accr = '0;

  logic        in_ready, res_valid, res_sat;
  logic [31:0] res_count, res_err_count, res_max_ae;
  logic [63:0] res_sae;
  logic [99:0] res_sse;

  logic        in_ready_s, res_valid_s, res_sat_s;
  logic [3:0]  res_count_s, res_err_count_s;
  logic [31:0] res_max_ae_s;
  logic [35:0] res_sae_s;
  logic [63:0] res_sse_s;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  error_metric_acc dut (
    .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .appx(appx), .accr(accr), .clear(clear), .snap(snap),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_err_count(res_err_count), .res_max_ae(res_max_ae),
    .res_sae(res_sae), .res_sse(res_sse), .res_sat(res_sat)
  );

  error_metric_acc #(.WIDTH(32), .CNT_W(4), .SAE_W(36), .SSE_W(64)) dut_s (
    .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .appx(appx), .accr(accr), .clear(clear), .snap(snap),
    .res_valid(res_valid_s), .res_ready(res_ready),
    .res_count(res_count_s), .res_err_count(res_err_count_s), .res_max_ae(res_max_ae_s),
    .res_sae(res_sae_s), .res_sse(res_sse_s), .res_sat(res_sat_s)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int due; logic [31:0] a; logic [31:0] b;} smp_t;
  smp_t pq[$];

  logic [127:0] lim_cnt[2], lim_sae[2], lim_sse[2];
  logic [127:0] m_cnt[2], m_err[2], m_sae[2], m_sse[2];
  logic [127:0] s_cnt[2], s_err[2], s_sae[2], s_sse[2];
  logic [31:0]  m_max, s_max;
  bit           m_sat[2];
  bit           waiting, reporting, pend;
  int           rv_cycle, last_acc, cyc;

  initial begin
    lim_cnt[0] = (128'd1 << 32) - 1;  lim_cnt[1] = (128'd1 << 4) - 1;
    lim_sae[0] = (128'd1 << 64) - 1;  lim_sae[1] = (128'd1 << 36) - 1;
    lim_sse[0] = (128'd1 << 100) - 1; lim_sse[1] = (128'd1 << 64) - 1;
  end

  function automatic logic [127:0] clamp(input logic [127:0] v, input logic [127:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic zero_acc();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = '0; m_err[k] = '0; m_sae[k] = '0; m_sse[k] = '0; m_sat[k] = 1'b0;
    end
    m_max = '0;
  endtask

  task automatic model_reset();
    zero_acc();
    for (int k = 0; k < 2; k++) begin
      s_cnt[k] = '0; s_err[k] = '0; s_sae[k] = '0; s_sse[k] = '0;
    end
    s_max = '0;
    waiting = 0; reporting = 0; pend = 0;
    pq.delete();
    last_acc = -100;
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    longint       d;
    logic [63:0]  ae;
    logic [127:0] sq;
    d  = longint'($signed(a)) - longint'($signed(b));
    ae = (d < 0) ? 64'(-d) : 64'(d);
    sq = {64'd0, ae} * {64'd0, ae};
    for (int k = 0; k < 2; k++) begin
      if (m_cnt[k] + 1 > lim_cnt[k]) m_sat[k] = 1'b1;
      m_cnt[k] = clamp(m_cnt[k] + 1, lim_cnt[k]);
      if (ae != 0) begin
        if (m_err[k] + 1 > lim_cnt[k]) m_sat[k] = 1'b1;
        m_err[k] = clamp(m_err[k] + 1, lim_cnt[k]);
      end
      if (m_sae[k] + ae > lim_sae[k]) m_sat[k] = 1'b1;
      m_sae[k] = clamp(m_sae[k] + ae, lim_sae[k]);
      if (m_sse[k] + sq > lim_sse[k]) m_sat[k] = 1'b1;
      m_sse[k] = clamp(m_sse[k] + sq, lim_sse[k]);
    end
    if (ae[31:0] > m_max) m_max = ae[31:0];
  endtask

  initial begin
    cyc = 0;
    model_reset();
  end

  // Samples accepted in cycle c land in the totals at the end of c+3; a snapshot is
  // visible two cycles after snap, or five after the last accepted sample if later.
  always @(posedge Clk) begin
    bit idle;
    if (!Rst_n) model_reset();
    else begin
      idle = !waiting && !reporting;
      if (idle && clear) begin
        zero_acc();
        pq.delete();
        last_acc = -100;
      end else begin
        while (pq.size() > 0 && pq[0].due == cyc) begin
          apply(pq[0].a, pq[0].b);
          void'(pq.pop_front());
        end
        if (idle && in_valid) begin
          pq.push_back('{cyc + 3, appx, accr});
          last_acc = cyc;
        end
        if (idle && snap) begin
          waiting  = 1;
          rv_cycle = (cyc + 2 > last_acc + 5) ? cyc + 2 : last_acc + 5;
        end
        if (!idle && clear) pend = 1;
        if (reporting && res_ready) begin
          reporting = 0;
          if (pend) zero_acc();
          pend = 0;
        end
        if (waiting && rv_cycle == cyc + 1) begin
          waiting = 0;
          reporting = 1;
          for (int k = 0; k < 2; k++) begin
            s_cnt[k] = m_cnt[k]; s_err[k] = m_err[k]; s_sae[k] = m_sae[k]; s_sse[k] = m_sse[k];
          end
          s_max = m_max;
        end
      end
    end
    cyc++;
  end

  always @(negedge Clk) begin
    if (Rst_n) begin
      chk("cmp_in_ready", in_ready, !waiting && !reporting && !clear);
      chk("cmp_in_ready_s", in_ready_s, !waiting && !reporting && !clear);
      chk("cmp_res_valid", res_valid, reporting);
      chk("cmp_res_valid_s", res_valid_s, reporting);
      chk("cmp_count", res_count, s_cnt[0]);
      chk("cmp_err", res_err_count, s_err[0]);
      chk("cmp_max", res_max_ae, s_max);
      chk("cmp_sae", res_sae, s_sae[0]);
      chk("cmp_sse", res_sse, s_sse[0]);
      chk("cmp_sat", res_sat, m_sat[0]);
      chk("cmp_count_s", res_count_s, s_cnt[1]);
      chk("cmp_err_s", res_err_count_s, s_err[1]);
      chk("cmp_max_s", res_max_ae_s, s_max);
      chk("cmp_sae_s", res_sae_s, s_sae[1]);
      chk("cmp_sse_s", res_sse_s, s_sse[1]);
      chk("cmp_sat_s", res_sat_s, m_sat[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; appx = a; accr = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1;
    step();
    snap = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic wait_report(output int n);
    n = 0;
    while (!res_valid && n < 50) begin
      step();
      n++;
    end
    chk("report_timeout", res_valid, 1'b1);
  endtask

  task automatic ack();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  int n;
  int r;

  initial begin
    repeat (3) step();
    Rst_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_count", res_count, 0);
    chk("rst_sat", res_sat, 1'b0);

    // exact samples
    repeat (4) send(32'd5, 32'd5);
    do_snap();
    wait_report(n);
    chk("exact_count", res_count, 4);
    chk("exact_err", res_err_count, 0);
    chk("exact_max", res_max_ae, 0);
    chk("exact_sae", res_sae, 0);
    chk("exact_sse", res_sse, 0);
    chk("exact_sat", res_sat, 1'b0);
    ack();

    // mixed errors
    do_clear();
    send(32'd10, 32'd7);
    send(-32'sd3, 32'd1);
    send(32'd100, 32'd100);
    do_snap();
    wait_report(n);
    chk("mixed_count", res_count, 3);
    chk("mixed_err", res_err_count, 2);
    chk("mixed_max", res_max_ae, 4);
    chk("mixed_sae", res_sae, 7);
    chk("mixed_sse", res_sse, 25);
    chk("model_pin_mixed_sse", s_sse[0], 25);
    ack();

    // extreme error
    do_clear();
    send(32'h7FFF_FFFF, 32'h8000_0000);
    do_snap();
    wait_report(n);
    chk("ext_max", res_max_ae, 32'hFFFF_FFFF);
    chk("ext_sae", res_sae, 64'hFFFF_FFFF);
    chk("ext_sse", res_sse, 100'hFFFF_FFFE_0000_0001);
    chk("ext_sat", res_sat, 1'b0);
    chk("ext_sat_s", res_sat_s, 1'b0);
    chk("model_pin_ext_sse", s_sse[0], 128'hFFFF_FFFE_0000_0001);
    ack();

    // counter saturation on the 4-bit instance
    do_clear();
    repeat (17) send(32'd1, 32'd0);
    do_snap();
    wait_report(n);
    chk("sat_count_s", res_count_s, 15);
    chk("sat_err_s", res_err_count_s, 15);
    chk("sat_flag_s", res_sat_s, 1'b1);
    chk("sat_count_wide", res_count, 17);
    chk("sat_flag_wide", res_sat, 1'b0);
    ack();

    // back-pressure, drain latency and clear during REPORT
    do_clear();
    repeat (3) send(32'd20, 32'd4);
    do_snap();
    wait_report(n);
    chk("drain_latency", n, 3);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_count", res_count, 3);
      chk("hold_sae", res_sae, 48);
      clear = (i == 5);
      step();
    end
    clear = 1'b0;
    ack();
    chk("after_ack_valid", res_valid, 1'b0);
    chk("after_ack_in_ready", in_ready, 1'b1);
    chk("after_ack_count", res_count, 3);
    do_snap();
    wait_report(n);
    chk("empty_latency", n, 1);
    chk("post_clear_count", res_count, 0);
    chk("post_clear_sse", res_sse, 0);
    ack();

    // clear + snap + in_valid together
    repeat (3) send(32'd9, 32'd2);
    clear = 1'b1; snap = 1'b1; in_valid = 1'b1; appx = 32'd50; accr = 32'd1;
    step();
    clear = 1'b0; snap = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("simul_no_report", res_valid, 1'b0);
      step();
    end
    do_snap();
    wait_report(n);
    chk("simul_count", res_count, 0);
    chk("simul_sae", res_sae, 0);
    ack();

    // reset while draining
    repeat (3) send(32'd8, 32'd1);
    do_snap();
    Rst_n = 1'b0;
    #2;
    chk("rst_mid_valid", res_valid, 1'b0);
    step();
    Rst_n = 1'b1;
    #2;
    chk("rst_rel_valid", res_valid, 1'b0);
    chk("rst_rel_in_ready", in_ready, 1'b1);
    chk("rst_rel_count", res_count, 0);
    step();
    do_snap();
    wait_report(n);
    chk("rst_after_count", res_count, 0);
    ack();

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 3);
      appx = $urandom;
      if (r == 0) accr = appx;
      else if (r == 1) accr = appx + 32'($urandom_range(0, 40)) - 32'd20;
      else accr = $urandom;
      clear = ($urandom_range(0, 79) == 0);
      snap = ($urandom_range(0, 29) == 0);
      res_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    in_valid = 1'b0; clear = 1'b0; snap = 1'b0; res_ready = 1'b1;
    repeat (20) step();
    res_ready = 1'b0;
    do_snap();
    wait_report(n);
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
